// File: rtl/div_unit_if.sv
// Request/response bundle between the ID/EX stage and the divider.
// Ports: start_i/funct3_i/word_i/operand1_i/operand2_i/flush_i go toward the divider;
//        busy_o/done_o/result_o come back. master = pipeline side, slave = divider.
interface div_unit_if #(
   parameter int XLEN = 64
);
   logic            start_i;
   logic [2:0]      funct3_i;
   logic            word_i;
   logic [XLEN-1:0] operand1_i;
   logic [XLEN-1:0] operand2_i;
   logic            flush_i;
   logic            busy_o;
   logic            done_o;
   logic [XLEN-1:0] result_o;

   modport master (
      output start_i, funct3_i, word_i, operand1_i, operand2_i, flush_i,
      input  busy_o, done_o, result_o
   );

   modport slave (
      input  start_i, funct3_i, word_i, operand1_i, operand2_i, flush_i,
      output busy_o, done_o, result_o
   );
endinterface

// File: rtl/div_unit.sv
// Purpose: iterative restoring radix-2 divider for DIV/DIVU/REM/REMU and their W forms.
// Latency: accepted in cycle T -> busy_o in T+1..T+N (N=64, or 32 for W), done_o pulse at T+N+1.
// Backpressure: none; EX stalls on busy_o, start_i is ignored outside IDLE, flush_i aborts.
// Ports: clock, reset (async, active high), bus (div_unit_if.slave).
// Option: define DIV_FASTPATH_EN to finish divide-by-zero and signed overflow in one cycle
//         (IDLE->DONE, done_o at T+1, busy_o never raised).
module div_unit #(
   parameter int XLEN = 64
) (
   input  logic      clock,
   input  logic      reset,
   div_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, 31'b0};

   state_t          state, state_nxt;
   logic [5:0]      cnt;
   logic            op_rem, op_word, neg_q, neg_r, div_zero, ovf;
   logic [XLEN-1:0] a_ext, div_mag, quo, rem, result;

   // ---------------- request decode (only meaningful in the accept cycle)
   logic            accept, in_uns, in_sa, in_sb, in_dz, in_ovf, fast_hit;
   logic [XLEN-1:0] in_a, in_b, in_amag, in_bmag, in_dvd, fast_res;

   assign accept  = (state == IDLE) && bus.start_i && bus.funct3_i[2] && !bus.flush_i;
   assign in_uns  = bus.funct3_i[0];

   // W forms only look at the low word, extended according to signedness.
   assign in_a = !bus.word_i ? bus.operand1_i :
                 in_uns ? {{(XLEN-32){1'b0}}, bus.operand1_i[31:0]}
                        : {{(XLEN-32){bus.operand1_i[31]}}, bus.operand1_i[31:0]};
   assign in_b = !bus.word_i ? bus.operand2_i :
                 in_uns ? {{(XLEN-32){1'b0}}, bus.operand2_i[31:0]}
                        : {{(XLEN-32){bus.operand2_i[31]}}, bus.operand2_i[31:0]};

   assign in_sa   = !in_uns && in_a[XLEN-1];
   assign in_sb   = !in_uns && in_b[XLEN-1];
   assign in_amag = in_sa ? -in_a : in_a;
   assign in_bmag = in_sb ? -in_b : in_b;
   assign in_dz   = (in_b == '0);
   assign in_ovf  = !in_uns && (in_b == '1) && (in_a == (bus.word_i ? MIN_W : MIN_D));

   // A W dividend is parked in the top half so its MSB is the first bit shifted out;
   // after 32 steps the quotient sits in the low word.
   assign in_dvd  = bus.word_i ? {in_amag[31:0], {(XLEN-32){1'b0}}} : in_amag;

`ifdef DIV_FASTPATH_EN
   assign fast_hit = in_dz || in_ovf;
`else
   assign fast_hit = 1'b0;
`endif

   // ---------------- one restoring step
   logic [XLEN:0]   rem_sh;
   logic            ge;
   logic [XLEN-1:0] rem_nxt, quo_nxt;

   assign rem_sh  = {rem, quo[XLEN-1]};
   assign ge      = (rem_sh >= {1'b0, div_mag});
   // When ge holds the difference is below the divisor, so 64-bit wraparound is exact.
   assign rem_nxt = ge ? (rem_sh[XLEN-1:0] - div_mag) : rem_sh[XLEN-1:0];
   assign quo_nxt = {quo[XLEN-2:0], ge};

   // Sign fix-up, special cases and W sign extension of the final value.
   function automatic logic [XLEN-1:0] finish(
      input logic [XLEN-1:0] q_mag, r_mag, a_val,
      input logic            is_rem, is_word, nq, nr, dz, of
   );
      logic [XLEN-1:0] q, r, res;
      if (dz) begin
         q = '1;
         r = a_val;
      end else if (of) begin
         q = a_val;
         r = '0;
      end else begin
         q = nq ? -q_mag : q_mag;
         r = nr ? -r_mag : r_mag;
      end
      res = is_rem ? r : q;
      if (is_word) res = {{(XLEN-32){res[31]}}, res[31:0]};
      return res;
   endfunction

   assign fast_res = finish('0, '0, in_a, bus.funct3_i[1], bus.word_i, 1'b0, 1'b0, in_dz, in_ovf);

   // ---------------- FSM
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = fast_hit ? DONE : CALC;
         CALC:    if (bus.flush_i) state_nxt = IDLE;
                  else if (cnt == 6'd0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- datapath
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         op_rem   <= 1'b0;
         op_word  <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         ovf      <= 1'b0;
         a_ext    <= '0;
         div_mag  <= '0;
         quo      <= '0;
         rem      <= '0;
         result   <= '0;
      end else if (accept) begin
         op_rem   <= bus.funct3_i[1];
         op_word  <= bus.word_i;
         neg_q    <= in_sa ^ in_sb;
         neg_r    <= in_sa;
         div_zero <= in_dz;
         ovf      <= in_ovf;
         a_ext    <= in_a;
         div_mag  <= in_bmag;
         quo      <= in_dvd;
         rem      <= '0;
         cnt      <= bus.word_i ? 6'd31 : 6'd63;
         if (fast_hit) result <= fast_res;
      end else if (state == CALC) begin
         quo <= quo_nxt;
         rem <= rem_nxt;
         if (bus.flush_i)      cnt <= '0;
         else if (cnt != 6'd0) cnt <= cnt - 6'd1;
         // Last step lands straight in the result register on the edge into DONE.
         if (state_nxt == DONE)
            result <= finish(quo_nxt, rem_nxt, a_ext, op_rem, op_word, neg_q, neg_r, div_zero, ovf);
      end
   end

   assign bus.busy_o   = (state == CALC);
   assign bus.done_o   = (state == DONE);
   assign bus.result_o = result;

endmodule
